apb_i2c_arbiter: RTL and testbench

- Two-requester APB master that shares the APB-to-I2C bridge slave between clients, e.g. a CPU-side command port and a DMA engine.
- Round-robin arbitration over whole transfers; generates the APB SETUP/ACCESS sequence and waits on PREADY.
- Aborts a transfer with an error if PREADY does not arrive within a bounded number of cycles; the slave never readies unmapped addresses.
- Returns read data, slave error and timeout status to the granted requester.

---
 rtl/apb_i2c_pkg.sv | 24 ++
 rtl/apb_i2c_arbiter_if.sv | 41 ++++
 rtl/apb_rr_arb2.sv | 36 +++
 rtl/apb_i2c_arbiter.sv | 108 ++++++++++
 tb/tb_apb_i2c_arbiter.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/apb_i2c_pkg.sv
// Shared types and constants for the APB-to-I2C bridge arbiter.
// Revision: 1.0
`default_nettype none

package apb_i2c_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  // Register map of the APB-to-I2C bridge slave
  localparam logic [31:0] ADDR_TX_FIFO = 32'h0000_0000;
  localparam logic [31:0] ADDR_RX_FIFO = 32'h0000_0004;
  localparam logic [31:0] ADDR_CONFIG  = 32'h0000_0008;
  localparam logic [31:0] ADDR_TIMEOUT = 32'h0000_000C;

  localparam int DEFAULT_TIMEOUT_CYCLES = 16;

endpackage

`default_nettype wire

// File: rtl/apb_i2c_arbiter_if.sv
// Requester and APB bus bundle for the two-client APB-to-I2C arbiter.
// Revision: 1.0
`default_nettype none

interface apb_i2c_arbiter_if;
  logic [1:0]  REQ_VALID;
  logic [1:0]  REQ_WRITE;
  logic [31:0] REQ_ADDR_0;
  logic [31:0] REQ_ADDR_1;
  logic [31:0] REQ_WDATA_0;
  logic [31:0] REQ_WDATA_1;
  logic [1:0]  RSP_DONE;
  logic [31:0] RSP_RDATA;
  logic        RSP_ERR;
  logic        RSP_TIMEOUT;
  logic        BUSY;
  logic        PSELx;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  modport master (
    input  REQ_VALID, REQ_WRITE, REQ_ADDR_0, REQ_ADDR_1, REQ_WDATA_0, REQ_WDATA_1,
    output RSP_DONE, RSP_RDATA, RSP_ERR, RSP_TIMEOUT, BUSY,
    output PSELx, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    output REQ_VALID, REQ_WRITE, REQ_ADDR_0, REQ_ADDR_1, REQ_WDATA_0, REQ_WDATA_1,
    input  RSP_DONE, RSP_RDATA, RSP_ERR, RSP_TIMEOUT, BUSY,
    input  PSELx, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

`default_nettype wire

// File: rtl/apb_rr_arb2.sv
// Two-way round-robin arbiter; the pointer only moves when a grant is taken.
// Revision: 1.0
`default_nettype none

module apb_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] gnt
);

  // Set when requester 1 was granted most recently; reset favours requester 0
  logic last_one;

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_one ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_one <= 1'b1;
    end else if (update && (gnt != 2'b00)) begin
      last_one <= gnt[1];
    end
  end

endmodule

`default_nettype wire

// File: rtl/apb_i2c_arbiter.sv
// Two-requester APB master sharing the APB-to-I2C bridge with PREADY timeout abort.
// Revision: 1.0
`default_nettype none

module apb_i2c_arbiter
  import apb_i2c_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int CNT_W          = 8
) (
  input  logic               PCLK,
  input  logic               PRESETn,
  apb_i2c_arbiter_if.master  bus
);

  localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT_CYCLES);

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [1:0]       gnt;
  logic [1:0]       grant;

  apb_rr_arb2 u_arb (
    .clk    (PCLK),
    .rst_n  (PRESETn),
    .req    (bus.REQ_VALID),
    .update (state == ST_IDLE),
    .gnt    (gnt)
  );

  // Saturating increment so the wait counter can never wrap
  assign cnt_inc = (wait_cnt == {CNT_W{1'b1}}) ? wait_cnt : wait_cnt + CNT_W'(1);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state           <= ST_IDLE;
      wait_cnt        <= '0;
      grant           <= 2'b00;
      bus.PSELx       <= 1'b0;
      bus.PENABLE     <= 1'b0;
      bus.PWRITE      <= 1'b0;
      bus.PADDR       <= '0;
      bus.PWDATA      <= '0;
      bus.BUSY        <= 1'b0;
      bus.RSP_DONE    <= 2'b00;
      bus.RSP_RDATA   <= '0;
      bus.RSP_ERR     <= 1'b0;
      bus.RSP_TIMEOUT <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|bus.REQ_VALID) begin
            grant       <= gnt;
            bus.PWRITE  <= gnt[1] ? bus.REQ_WRITE[1] : bus.REQ_WRITE[0];
            bus.PADDR   <= gnt[1] ? bus.REQ_ADDR_1   : bus.REQ_ADDR_0;
            bus.PWDATA  <= gnt[1] ? bus.REQ_WDATA_1  : bus.REQ_WDATA_0;
            bus.PSELx   <= 1'b1;
            bus.PENABLE <= 1'b0;
            bus.BUSY    <= 1'b1;
            state       <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          bus.PENABLE <= 1'b1;
          state       <= ST_ACCESS;
        end
        ST_ACCESS: begin
          // PREADY is checked first so it wins over a timeout on the same edge
          if (bus.PREADY) begin
            bus.PSELx     <= 1'b0;
            bus.PENABLE   <= 1'b0;
            bus.RSP_DONE  <= grant;
            bus.RSP_RDATA <= bus.PWRITE ? 32'h0 : bus.PRDATA;
            bus.RSP_ERR   <= bus.PSLVERR;
            state         <= ST_RESP;
          end else if (cnt_inc == TIMEOUT_LIM) begin
            wait_cnt        <= cnt_inc;
            bus.PSELx       <= 1'b0;
            bus.PENABLE     <= 1'b0;
            bus.RSP_DONE    <= grant;
            bus.RSP_RDATA   <= '0;
            bus.RSP_ERR     <= 1'b1;
            bus.RSP_TIMEOUT <= 1'b1;
            state           <= ST_RESP;
          end else begin
            wait_cnt <= cnt_inc;
          end
        end
        ST_RESP: begin
          wait_cnt        <= '0;
          bus.BUSY        <= 1'b0;
          bus.RSP_DONE    <= 2'b00;
          bus.RSP_RDATA   <= '0;
          bus.RSP_ERR     <= 1'b0;
          bus.RSP_TIMEOUT <= 1'b0;
          state           <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_apb_i2c_arbiter.sv
// Self-checking bench for apb_i2c_arbiter: vector table plus arbitration/reset sequences.
// Revision: 1.0
`default_nettype none

module tb_apb_i2c_arbiter;
  import apb_i2c_pkg::*;

  logic PCLK = 1'b0;
  logic PRESETn = 1'b0;
  always #5 PCLK = ~PCLK;

  apb_i2c_arbiter_if bus ();

  apb_i2c_arbiter #(.TIMEOUT_CYCLES(16), .CNT_W(8)) dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .bus     (bus)
  );

  typedef struct {
    logic [1:0]  req;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          wait_n;
    logic [31:0] srd;
    logic        serr;
    logic [1:0]  edone;
    logic [31:0] erd;
    logic        eerr;
    logic        eto;
    int          ebusy;
    int          epsel;
  } vec_t;

  typedef struct {
    logic [1:0]  done;
    logic [31:0] rdata;
    logic        err;
    logic        to;
  } exp_t;

  exp_t        sb[$];
  vec_t        vecs[7];
  int          n_checks = 0;
  int          n_err = 0;
  int          wait_cfg = 0;
  logic [31:0] rdata_cfg = '0;
  logic        serr_cfg = 1'b0;
  int          acc_cnt = 0;

  function automatic bit mapped(input logic [31:0] a);
    return (a == ADDR_TX_FIFO) || (a == ADDR_RX_FIFO) || (a == ADDR_CONFIG) || (a == ADDR_TIMEOUT);
  endfunction

  // Slave model: ready after wait_cfg ACCESS cycles, never for unmapped addresses
  always @(negedge PCLK) begin
    if (bus.PSELx && bus.PENABLE) begin
      if (acc_cnt == wait_cfg && mapped(bus.PADDR)) begin
        bus.PREADY  = 1'b1;
        bus.PRDATA  = rdata_cfg;
        bus.PSLVERR = serr_cfg;
      end else begin
        bus.PREADY  = 1'b0;
        bus.PRDATA  = 32'hBAD0_BAD0;
        bus.PSLVERR = 1'b1;
      end
      acc_cnt++;
    end else begin
      bus.PREADY  = 1'b0;
      bus.PRDATA  = '0;
      bus.PSLVERR = 1'b0;
      acc_cnt     = 0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic wait_done(input int max_cyc, output int cyc, output int busy_n, output int psel_n);
    exp_t e;
    bit   got;
    got = 1'b0;
    cyc = 0; busy_n = 0; psel_n = 0;
    while (!got && cyc < max_cyc) begin
      @(negedge PCLK);
      cyc++;
      if (bus.BUSY)  busy_n++;
      if (bus.PSELx) psel_n++;
      if (bus.RSP_DONE != 2'b00) begin
        got = 1'b1;
        chk("done_onehot", $countones(bus.RSP_DONE), 1);
        if (sb.size() == 0) begin
          n_checks++; n_err++;
          $display("FAIL unexpected_done: actual=%b required=no completion", bus.RSP_DONE);
        end else begin
          e = sb.pop_front();
          chk("rsp_done",    {30'h0, bus.RSP_DONE},    {30'h0, e.done});
          chk("rsp_rdata",   bus.RSP_RDATA,            e.rdata);
          chk("rsp_err",     {31'h0, bus.RSP_ERR},     {31'h0, e.err});
          chk("rsp_timeout", {31'h0, bus.RSP_TIMEOUT}, {31'h0, e.to});
        end
      end
    end
    if (!got) begin
      n_checks++; n_err++;
      $display("FAIL done_wait: actual=no RSP_DONE required=RSP_DONE within %0d cycles", max_cyc);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int   cyc, busy_n, psel_n;
    exp_t e;
    wait_cfg  = v.wait_n;
    rdata_cfg = v.srd;
    serr_cfg  = v.serr;
    if (v.req[0]) begin
      bus.REQ_WRITE[0] = v.wr; bus.REQ_ADDR_0 = v.addr; bus.REQ_WDATA_0 = v.wdata;
    end
    if (v.req[1]) begin
      bus.REQ_WRITE[1] = v.wr; bus.REQ_ADDR_1 = v.addr; bus.REQ_WDATA_1 = v.wdata;
    end
    e = '{v.edone, v.erd, v.eerr, v.eto};
    sb.push_back(e);
    bus.REQ_VALID = v.req;
    wait_done(64, cyc, busy_n, psel_n);
    bus.REQ_VALID = 2'b00;
    chk($sformatf("v%0d_latency", idx), cyc,    v.ebusy);
    chk($sformatf("v%0d_busy", idx),    busy_n, v.ebusy);
    chk($sformatf("v%0d_psel", idx),    psel_n, v.epsel);
    chk($sformatf("v%0d_paddr", idx),   bus.PADDR, v.addr);
    chk($sformatf("v%0d_pwrite", idx),  {31'h0, bus.PWRITE}, {31'h0, v.wr});
    if (v.wr) chk($sformatf("v%0d_pwdata", idx), bus.PWDATA, v.wdata);
    @(negedge PCLK);
    chk($sformatf("v%0d_idle_ctrl", idx),
        {27'h0, bus.BUSY, bus.PSELx, bus.PENABLE, bus.RSP_ERR, bus.RSP_TIMEOUT}, 32'h0);
    chk($sformatf("v%0d_idle_rsp", idx), {bus.RSP_RDATA[29:0], bus.RSP_DONE}, 32'h0);
  endtask

  initial begin
    int   cyc, busy_n, psel_n;
    exp_t e;
    bus.REQ_VALID = 2'b00; bus.REQ_WRITE = 2'b00;
    bus.REQ_ADDR_0 = '0; bus.REQ_ADDR_1 = '0;
    bus.REQ_WDATA_0 = '0; bus.REQ_WDATA_1 = '0;

    //          req    wr    addr    wdata         wait srd           serr  done   rdata         err   to    busy psel
    vecs[0] = '{2'b01, 1'b1, 32'd8,  32'h0000_01A5, 0,  32'h1234_5678, 1'b0, 2'b01, 32'h0,        1'b0, 1'b0, 3,  2};
    vecs[1] = '{2'b10, 1'b0, 32'd4,  32'h0,         3,  32'hDEAD_BEEF, 1'b0, 2'b10, 32'hDEAD_BEEF, 1'b0, 1'b0, 6,  5};
    vecs[2] = '{2'b01, 1'b0, 32'd16, 32'h0,         0,  32'h7777_7777, 1'b0, 2'b01, 32'h0,        1'b1, 1'b1, 18, 17};
    vecs[3] = '{2'b10, 1'b1, 32'd12, 32'h0000_00C3, 0,  32'h5555_AAAA, 1'b1, 2'b10, 32'h0,        1'b1, 1'b0, 3,  2};
    vecs[4] = '{2'b01, 1'b0, 32'd0,  32'h0,         15, 32'hCAFE_0001, 1'b0, 2'b01, 32'hCAFE_0001, 1'b0, 1'b0, 18, 17};
    vecs[5] = '{2'b10, 1'b0, 32'd8,  32'h0,         1,  32'h0000_0055, 1'b1, 2'b10, 32'h0000_0055, 1'b1, 1'b0, 4,  3};
    vecs[6] = '{2'b01, 1'b1, 32'd0,  32'hA5A5_0F0F, 2,  32'h1111_2222, 1'b0, 2'b01, 32'h0,        1'b0, 1'b0, 5,  4};

    repeat (3) @(negedge PCLK);
    chk("rst_ctrl", {28'h0, bus.PSELx, bus.PENABLE, bus.PWRITE, bus.BUSY}, 32'h0);
    chk("rst_done", {30'h0, bus.RSP_DONE}, 32'h0);
    chk("rst_paddr", bus.PADDR, 32'h0);
    chk("rst_pwdata", bus.PWDATA, 32'h0);
    chk("rst_rsp", {bus.RSP_RDATA[29:0], bus.RSP_ERR, bus.RSP_TIMEOUT}, 32'h0);
    PRESETn = 1'b1;
    @(negedge PCLK);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // Fields changed and request dropped right after grant must not affect the transfer
    wait_cfg = 2; rdata_cfg = 32'h600D_0008; serr_cfg = 1'b0;
    bus.REQ_WRITE = 2'b00; bus.REQ_ADDR_0 = 32'd8;
    e = '{2'b01, 32'h600D_0008, 1'b0, 1'b0};
    sb.push_back(e);
    bus.REQ_VALID = 2'b01;
    @(negedge PCLK);
    bus.REQ_VALID = 2'b00; bus.REQ_ADDR_0 = 32'h10; bus.REQ_WRITE = 2'b11; bus.REQ_WDATA_0 = 32'hFFFF_FFFF;
    wait_done(64, cyc, busy_n, psel_n);
    chk("latch_paddr", bus.PADDR, 32'd8);
    chk("latch_pwrite", {31'h0, bus.PWRITE}, 32'h0);
    @(negedge PCLK);

    // Reset in the middle of ACCESS: async drop, no completion for the lost transfer
    wait_cfg = 0;
    bus.REQ_WRITE = 2'b00; bus.REQ_ADDR_0 = 32'h10;
    bus.REQ_VALID = 2'b01;
    repeat (4) @(negedge PCLK);
    chk("pre_rst_access", {30'h0, bus.PSELx, bus.PENABLE}, 32'h3);
    bus.REQ_VALID = 2'b00;
    #2 PRESETn = 1'b0;
    #1 chk("rst_async", {29'h0, bus.PSELx, bus.PENABLE, bus.BUSY}, 32'h0);
    repeat (2) begin
      @(negedge PCLK);
      chk("rst_no_done", {30'h0, bus.RSP_DONE}, 32'h0);
    end
    PRESETn = 1'b1;

    // Both held continuously after reset: grants alternate 0,1,0,1 starting with 0
    bus.REQ_WRITE = 2'b11; bus.REQ_ADDR_0 = 32'd0; bus.REQ_ADDR_1 = 32'd0;
    bus.REQ_WDATA_0 = 32'h0000_00A0; bus.REQ_WDATA_1 = 32'h0000_00B1;
    for (int k = 0; k < 4; k++) begin
      e = '{(k % 2 == 0) ? 2'b01 : 2'b10, 32'h0, 1'b0, 1'b0};
      sb.push_back(e);
    end
    bus.REQ_VALID = 2'b11;
    for (int k = 0; k < 4; k++) begin
      wait_done(32, cyc, busy_n, psel_n);
      if (k > 0) chk("grant_spacing", cyc, 4);
      chk("rr_pwdata", bus.PWDATA, (k % 2 == 0) ? 32'h0000_00A0 : 32'h0000_00B1);
    end
    bus.REQ_VALID = 2'b00;
    repeat (3) @(negedge PCLK);
    chk("final_idle", {30'h0, bus.BUSY, bus.PSELx}, 32'h0);
    chk("sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
